// File: rtl/scan_shift_reg_if.sv
// -----------------------------------------------------------------------------
// scan_shift_reg_if
// Control/status bundle for the bar scanner.
//   master : drives ena, mode, div, load, clr; observes the scanner outputs
//   slave  : the scanner itself
// Signals:
//   ena          step enable
//   mode [1:0]   00 bounce, 01 rotate right, 10 rotate left, 11 one-shot right
//   div          prescaler divisor (one step every div+1 enabled cycles)
//   load         synchronous reload of the start position
//   clr          synchronous clear of period_count
//   Q [N-1:0]    bar pattern
//   dir          1 = moving toward LSB
//   tc_lsb       one-cycle pulse on arrival at bit 0
//   tc_msb       one-cycle pulse on arrival flush at bit N-1
//   period_count count of tc_lsb events (wraps)
//   done         one-shot finished (level)
// -----------------------------------------------------------------------------
interface scan_shift_reg_if #(
   parameter int N             = 8,
   parameter int COUNTER_WIDTH = 8,
   parameter int DIV_WIDTH     = 8
);
   logic                     ena;
   logic [1:0]               mode;
   logic [DIV_WIDTH-1:0]     div;
   logic                     load;
   logic                     clr;
   logic [N-1:0]             Q;
   logic                     dir;
   logic                     tc_lsb;
   logic                     tc_msb;
   logic [COUNTER_WIDTH-1:0] period_count;
   logic                     done;

   modport master (
      output ena, mode, div, load, clr,
      input  Q, dir, tc_lsb, tc_msb, period_count, done
   );

   modport slave (
      input  ena, mode, div, load, clr,
      output Q, dir, tc_lsb, tc_msb, period_count, done
   );
endinterface

// File: rtl/scan_shift_reg.sv
// -----------------------------------------------------------------------------
// scan_shift_reg
// Bar scanner: a run of W adjacent ones moves across an N-bit register in one
// of four modes (bounce, rotate right, rotate left, one-shot right sweep).
// Ports:
//   clk   rising-edge clock
//   rsta  asynchronous active-high reset
//   bus   scan_shift_reg_if.slave (ena, mode, div, load, clr in;
//         Q, dir, tc_lsb, tc_msb, period_count, done out)
// Optional feature macro: SCAN_SHIFT_REG_PRESCALER_EN
//   defined   : step prescaler active, one step every div+1 enabled cycles
//   undefined : no prescaler, every enabled cycle is a step, div ignored
// -----------------------------------------------------------------------------
module scan_shift_reg #(
   parameter int N             = 8,
   parameter int W             = 1,
   parameter int COUNTER_WIDTH = 8,
   parameter int DIV_WIDTH     = 8
) (
   input  logic            clk,
   input  logic            rsta,
   scan_shift_reg_if.slave bus
);
   localparam int PW = (N > 2) ? $clog2(N) : 1;
   localparam logic [PW-1:0] P_FLUSH = PW'(N - W);
   localparam logic [PW-1:0] P_TOP   = PW'(N - 1);

   typedef enum logic [1:0] {
      M_BOUNCE  = 2'b00,
      M_ROT_R   = 2'b01,
      M_ROT_L   = 2'b10,
      M_ONESHOT = 2'b11
   } mode_t;

   // W ones rotated left by p (bar may wrap across bit N-1 / bit 0)
   function automatic logic [N-1:0] f_bar(input logic [PW-1:0] p);
      logic [2*N-1:0] v_dbl;
      v_dbl = {{(2*N-W){1'b0}}, {W{1'b1}}} << p;
      return v_dbl[N-1:0] | v_dbl[2*N-1:N];
   endfunction

   logic [PW-1:0]            r_pos;
   logic [N-1:0]             r_q;
   logic                     r_dir;
   logic                     r_done;
   logic                     r_tc_lsb;
   logic                     r_tc_msb;
   logic [COUNTER_WIDTH-1:0] r_pc;
   mode_t                    r_mode;

   mode_t                    w_mode;
   logic                     w_tick;
   logic                     w_step;
   logic                     w_mode_chg;
   logic                     w_down;
   logic [PW-1:0]            w_pos_nxt;
   logic                     w_dir_nxt;
   logic                     w_done_nxt;
   logic                     w_tcl_nxt;
   logic                     w_tcm_nxt;
   logic [COUNTER_WIDTH-1:0] w_pc_nxt;

`ifdef SCAN_SHIFT_REG_PRESCALER_EN
   logic [DIV_WIDTH-1:0] r_psc;

   // >= rather than == so lowering div mid-count cannot stall the scanner
   assign w_tick = (r_psc >= bus.div);

   always_ff @(posedge clk or posedge rsta) begin
      if (rsta)          r_psc <= '0;
      else if (bus.load) r_psc <= '0;
      else if (bus.ena)  r_psc <= w_tick ? '0 : r_psc + DIV_WIDTH'(1);
   end
`else
   logic w_unused_div;
   assign w_tick       = 1'b1;
   assign w_unused_div = ^bus.div;
`endif

   assign w_mode     = mode_t'(bus.mode);
   assign w_mode_chg = (w_mode != r_mode);
   assign w_step     = bus.ena & w_tick & ~bus.load;
   // Bounce direction: beyond the flush point always go down; a stale dir left
   // by a rotate mode at either end is reflected instead of over-running.
   assign w_down     = (r_pos >= P_FLUSH) || (r_dir && (r_pos != '0));

   always_comb begin
      w_pos_nxt  = r_pos;
      w_dir_nxt  = r_dir;
      w_done_nxt = r_done;
      w_tcl_nxt  = 1'b0;
      w_tcm_nxt  = 1'b0;
      if (bus.load) begin
         w_pos_nxt  = P_FLUSH;
         w_dir_nxt  = 1'b1;
         w_done_nxt = 1'b0;
      end else begin
         if (w_mode_chg) w_done_nxt = 1'b0;
         if (w_step) begin
            unique case (w_mode)
               M_BOUNCE: begin
                  if (w_down) begin
                     w_pos_nxt = r_pos - PW'(1);
                     w_dir_nxt = 1'b1;
                     if (r_pos == PW'(1)) begin
                        w_tcl_nxt = 1'b1;
                        w_dir_nxt = 1'b0;
                     end
                  end else begin
                     w_pos_nxt = r_pos + PW'(1);
                     w_dir_nxt = 1'b0;
                     if (w_pos_nxt == P_FLUSH) begin
                        w_tcm_nxt = 1'b1;
                        w_dir_nxt = 1'b1;
                     end
                  end
               end
               M_ROT_R: begin
                  w_pos_nxt = (r_pos == '0) ? P_TOP : r_pos - PW'(1);
                  w_dir_nxt = 1'b1;
                  w_tcl_nxt = (r_pos == PW'(1));
               end
               M_ROT_L: begin
                  w_pos_nxt = (r_pos == P_TOP) ? '0 : r_pos + PW'(1);
                  w_dir_nxt = 1'b0;
                  w_tcm_nxt = (w_pos_nxt == P_FLUSH);
               end
               M_ONESHOT: begin
                  if (!r_done) begin
                     w_pos_nxt = (r_pos == '0) ? P_TOP : r_pos - PW'(1);
                     w_dir_nxt = 1'b1;
                     if (r_pos == PW'(1)) begin
                        w_tcl_nxt  = 1'b1;
                        w_done_nxt = 1'b1;
                     end
                  end
               end
            endcase
         end
      end
      if (bus.clr)        w_pc_nxt = '0;
      else if (w_tcl_nxt) w_pc_nxt = r_pc + COUNTER_WIDTH'(1);
      else                w_pc_nxt = r_pc;
   end

   always_ff @(posedge clk or posedge rsta) begin
      if (rsta) begin
         r_pos    <= P_FLUSH;
         r_q      <= f_bar(P_FLUSH);
         r_dir    <= 1'b1;
         r_done   <= 1'b0;
         r_tc_lsb <= 1'b0;
         r_tc_msb <= 1'b0;
         r_pc     <= '0;
         r_mode   <= M_BOUNCE;
      end else begin
         r_pos    <= w_pos_nxt;
         r_q      <= f_bar(w_pos_nxt);
         r_dir    <= w_dir_nxt;
         r_done   <= w_done_nxt;
         r_tc_lsb <= w_tcl_nxt;
         r_tc_msb <= w_tcm_nxt;
         r_pc     <= w_pc_nxt;
         r_mode   <= w_mode;
      end
   end

   assign bus.Q            = r_q;
   assign bus.dir          = r_dir;
   assign bus.tc_lsb       = r_tc_lsb;
   assign bus.tc_msb       = r_tc_msb;
   assign bus.period_count = r_pc;
   assign bus.done         = r_done;
endmodule

// File: tb/tb_scan_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_scan_shift_reg
// Drives three scanners (N=8, W=1/3/2) from shared stimulus. A behavioural
// model pushes the expected outputs of every cycle into a queue before the
// clock edge; they are popped and compared after the edge. Directed constant
// checks cover the documented scenarios.
// -----------------------------------------------------------------------------
module tb_scan_shift_reg;
   logic       clk  = 1'b0;
   logic       rsta = 1'b0;
   logic       ena;
   logic [1:0] mode;
   logic [7:0] div;
   logic       load;
   logic       clr;

   always #5 clk = ~clk;

   scan_shift_reg_if #(.N(8), .COUNTER_WIDTH(8), .DIV_WIDTH(8)) if0 ();
   scan_shift_reg_if #(.N(8), .COUNTER_WIDTH(8), .DIV_WIDTH(8)) if1 ();
   scan_shift_reg_if #(.N(8), .COUNTER_WIDTH(8), .DIV_WIDTH(8)) if2 ();

   assign if0.ena = ena;  assign if0.mode = mode;  assign if0.div = div;
   assign if0.load = load; assign if0.clr = clr;
   assign if1.ena = ena;  assign if1.mode = mode;  assign if1.div = div;
   assign if1.load = load; assign if1.clr = clr;
   assign if2.ena = ena;  assign if2.mode = mode;  assign if2.div = div;
   assign if2.load = load; assign if2.clr = clr;

   scan_shift_reg #(.N(8), .W(1), .COUNTER_WIDTH(8), .DIV_WIDTH(8)) u_dut0 (
      .clk(clk), .rsta(rsta), .bus(if0.slave));
   scan_shift_reg #(.N(8), .W(3), .COUNTER_WIDTH(8), .DIV_WIDTH(8)) u_dut1 (
      .clk(clk), .rsta(rsta), .bus(if1.slave));
   scan_shift_reg #(.N(8), .W(2), .COUNTER_WIDTH(8), .DIV_WIDTH(8)) u_dut2 (
      .clk(clk), .rsta(rsta), .bus(if2.slave));

   typedef struct {
      logic [7:0] q;
      logic       dir;
      logic       tcl;
      logic       tcm;
      logic [7:0] pc;
      logic       done;
   } exp_t;

   exp_t sb[$];
   int   ncmp = 0;
   int   nerr = 0;

   int         mw   [3] = '{1, 3, 2};
   int         mpos [3];
   logic       mdir [3];
   logic       mdone[3];
   logic       mtcl [3];
   logic       mtcm [3];
   logic [7:0] mpc  [3];
   logic [7:0] mpsc [3];
   logic [1:0] mprev;

   function automatic logic [7:0] bar(int p, int w);
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < w; i++) v[(p + i) % 8] = 1'b1;
      return v;
   endfunction

   task automatic chk8(string tag, logic [7:0] obs, logic [7:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(string tag, logic obs, logic exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int k = 0; k < 3; k++) begin
         mpos[k] = 8 - mw[k]; mdir[k] = 1'b1; mdone[k] = 1'b0;
         mtcl[k] = 1'b0; mtcm[k] = 1'b0; mpc[k] = '0; mpsc[k] = '0;
      end
      mprev = 2'b00;
   endtask

   // Model of one clock edge using the inputs currently driven
   task automatic m_step();
      logic chg;
      exp_t e;
      chg = (mode != mprev);
      for (int k = 0; k < 3; k++) begin
         int   fl;
         logic tick;
         fl   = 8 - mw[k];
         tick = 1'b1;
`ifdef SCAN_SHIFT_REG_PRESCALER_EN
         tick = (mpsc[k] >= div);
`endif
         mtcl[k] = 1'b0;
         mtcm[k] = 1'b0;
         if (load) begin
            mpos[k] = fl; mdir[k] = 1'b1; mdone[k] = 1'b0; mpsc[k] = '0;
         end else begin
            if (ena) mpsc[k] = tick ? 8'd0 : mpsc[k] + 8'd1;
            if (chg) mdone[k] = 1'b0;
            if (ena && tick) begin
               case (mode)
                  2'b00: begin
                     if (mpos[k] > fl) begin
                        mpos[k]--; mdir[k] = 1'b1;
                     end else if (mdir[k]) begin
                        mpos[k]--;
                        if (mpos[k] == 0) begin mtcl[k] = 1'b1; mdir[k] = 1'b0; end
                     end else begin
                        mpos[k]++;
                        if (mpos[k] == fl) begin mtcm[k] = 1'b1; mdir[k] = 1'b1; end
                     end
                  end
                  2'b01: begin
                     mpos[k] = (mpos[k] + 7) % 8; mdir[k] = 1'b1;
                     mtcl[k] = (mpos[k] == 0);
                  end
                  2'b10: begin
                     mpos[k] = (mpos[k] + 1) % 8; mdir[k] = 1'b0;
                     mtcm[k] = (mpos[k] == fl);
                  end
                  default: begin
                     if (!mdone[k]) begin
                        mpos[k] = (mpos[k] + 7) % 8; mdir[k] = 1'b1;
                        if (mpos[k] == 0) begin mtcl[k] = 1'b1; mdone[k] = 1'b1; end
                     end
                  end
               endcase
            end
         end
         if (clr)          mpc[k] = '0;
         else if (mtcl[k]) mpc[k] = mpc[k] + 8'd1;
         e.q = bar(mpos[k], mw[k]); e.dir = mdir[k]; e.tcl = mtcl[k];
         e.tcm = mtcm[k]; e.pc = mpc[k]; e.done = mdone[k];
         sb.push_back(e);
      end
      mprev = mode;
   endtask

   task automatic cmp_dut(int k, logic [7:0] q, logic d, logic tl, logic tm,
                          logic [7:0] pc, logic dn);
      exp_t e;
      if (sb.size() == 0) begin
         ncmp++; nerr++;
         $display("FAIL sb_empty dut=%0d observed=empty expected=entry", k);
         return;
      end
      e = sb.pop_front();
      chk8($sformatf("Q[%0d]", k), q, e.q);
      chk1($sformatf("dir[%0d]", k), d, e.dir);
      chk1($sformatf("tc_lsb[%0d]", k), tl, e.tcl);
      chk1($sformatf("tc_msb[%0d]", k), tm, e.tcm);
      chk8($sformatf("period_count[%0d]", k), pc, e.pc);
      chk1($sformatf("done[%0d]", k), dn, e.done);
   endtask

   task automatic cyc(int n);
      repeat (n) begin
         m_step();
         @(posedge clk);
         #1;
         cmp_dut(0, if0.Q, if0.dir, if0.tc_lsb, if0.tc_msb, if0.period_count, if0.done);
         cmp_dut(1, if1.Q, if1.dir, if1.tc_lsb, if1.tc_msb, if1.period_count, if1.done);
         cmp_dut(2, if2.Q, if2.dir, if2.tc_lsb, if2.tc_msb, if2.period_count, if2.done);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ena = 1'b1; mode = 2'b00; div = 8'd0; load = 1'b0; clr = 1'b0;
      #1 rsta = 1'b1;
      #1;
      chk8("rst_Q0", if0.Q, 8'h80);
      chk8("rst_Q1", if1.Q, 8'hE0);
      chk8("rst_Q2", if2.Q, 8'hC0);
      chk1("rst_dir", if0.dir, 1'b1);
      chk1("rst_tcl", if0.tc_lsb, 1'b0);
      chk1("rst_tcm", if0.tc_msb, 1'b0);
      chk8("rst_pc", if0.period_count, 8'd0);
      chk1("rst_done", if0.done, 1'b0);
      m_reset();
      #1 rsta = 1'b0;

      // bounce from reset
      cyc(5);
      chk8("w3_step5_Q", if1.Q, 8'h07);
      chk1("w3_step5_tcl", if1.tc_lsb, 1'b1);
      cyc(1);
      chk8("w3_step6_Q", if1.Q, 8'h0E);
      cyc(1);
      chk8("w1_step7_Q", if0.Q, 8'h01);
      chk1("w1_step7_tcl", if0.tc_lsb, 1'b1);
      chk8("w1_step7_pc", if0.period_count, 8'd1);
      chk1("w1_step7_dir", if0.dir, 1'b0);
      cyc(1);
      chk1("w1_step8_tcl", if0.tc_lsb, 1'b0);
      cyc(6);
      chk8("w1_step14_Q", if0.Q, 8'h80);
      chk1("w1_step14_tcm", if0.tc_msb, 1'b1);

      // rotate right
      mode = 2'b01; load = 1'b1; cyc(1); load = 1'b0;
      cyc(6);
      chk8("rr_step6_Q", if2.Q, 8'h03);
      chk1("rr_step6_tcl", if2.tc_lsb, 1'b1);
      cyc(1);
      chk8("rr_step7_Q", if2.Q, 8'h81);
      cyc(1);
      chk8("rr_step8_Q", if2.Q, 8'hC0);

      // rotate left, div set (ignored without the prescaler)
      mode = 2'b10; div = 8'd5; load = 1'b1; cyc(1); load = 1'b0;
      cyc(10);
      div = 8'd0;

      // one-shot
      mode = 2'b11; load = 1'b1; cyc(1); load = 1'b0;
      cyc(7);
      chk8("os_Q", if0.Q, 8'h01);
      chk1("os_done", if0.done, 1'b1);
      chk1("os_tcl", if0.tc_lsb, 1'b1);
      cyc(10);
      chk8("os_hold_Q", if0.Q, 8'h01);
      chk1("os_hold_done", if0.done, 1'b1);
      load = 1'b1; cyc(1); load = 1'b0;
      chk8("os_reload_Q", if0.Q, 8'h80);
      chk1("os_reload_done", if0.done, 1'b0);
      cyc(7);
      ena = 1'b0; mode = 2'b01; cyc(1); ena = 1'b1;
      chk1("os_modechg_done", if0.done, 1'b0);

      // bounce with ena held low
      mode = 2'b00; load = 1'b1; cyc(1); load = 1'b0;
      cyc(3);
      ena = 1'b0; cyc(3); ena = 1'b1;
      chk8("hold_Q", if0.Q, 8'h10);

      // clr coincident with tc_lsb
      cyc(3);
      clr = 1'b1; cyc(1); clr = 1'b0;
      chk1("clr_tcl", if0.tc_lsb, 1'b1);
      chk8("clr_pc", if0.period_count, 8'd0);

      // period_count wrap
      mode = 2'b01; load = 1'b1; clr = 1'b1; cyc(1); load = 1'b0; clr = 1'b0;
      cyc(7);
      chk8("wrap_pc1", if0.period_count, 8'd1);
      cyc(254 * 8);
      chk8("wrap_pc255", if0.period_count, 8'd255);
      cyc(8);
      chk8("wrap_pc0", if0.period_count, 8'd0);
      chk1("wrap_tcl", if0.tc_lsb, 1'b1);

`ifdef SCAN_SHIFT_REG_PRESCALER_EN
      mode = 2'b00; div = 8'd3; load = 1'b1; cyc(1); load = 1'b0;
      cyc(3);
      chk8("psc_wait_Q", if0.Q, 8'h80);
      cyc(1);
      chk8("psc_step_Q", if0.Q, 8'h40);
      ena = 1'b0; cyc(5); ena = 1'b1;
      cyc(3);
      chk8("psc_ena_wait_Q", if0.Q, 8'h40);
      cyc(1);
      chk8("psc_ena_step_Q", if0.Q, 8'h20);
      div = 8'd0;
`endif

      // asynchronous reset between edges
      cyc(3);
      #2 rsta = 1'b1;
      #1;
      chk8("arst_Q0", if0.Q, 8'h80);
      chk8("arst_Q1", if1.Q, 8'hE0);
      chk8("arst_pc", if0.period_count, 8'd0);
      chk1("arst_dir", if0.dir, 1'b1);
      m_reset();
      #1 rsta = 1'b0;
      mode = 2'b00;
      cyc(2);
      chk8("post_rst_Q", if0.Q, 8'h20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
